// File: rtl/input_pre_sram_pkg.sv
// input_pre_sram_pkg
// Shared constants, types and helpers for the input pre-processing SRAM.
//   PRE_SRAM_DW / PRE_SRAM_AW / PRE_SRAM_DP : default data width, address width, depth
//   pre_sram_word_t                          : one default-width data word
//   pre_sram_mask_w()                        : byte write-mask width for a data width
package input_pre_sram_pkg;

  localparam int PRE_SRAM_DW = 8;
  localparam int PRE_SRAM_AW = 10;
  localparam int PRE_SRAM_DP = 1024;

  typedef logic [PRE_SRAM_DW-1:0] pre_sram_word_t;

  // Number of byte lanes (and mask bits) for a data width that is a multiple of 8.
  function automatic int pre_sram_mask_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/input_pre_sram_bank.sv
// input_pre_sram_bank
// Byte-lane storage array: one memory per byte lane, each with its own write
// enable, and a registered read per lane. No reset on storage or read register.
// Optional feature macro: INPUT_PRE_SRAM_WRITE_THROUGH_EN
//   defined   : a written lane returns the new byte on rdata
//   undefined : read-first, rdata returns the contents before the write
// Ports:
//   clk     : clock
//   en      : access enable (in-range, selected, out of reset)
//   lane_we : per-lane write enable (already qualified by en)
//   addr    : word index into the implemented depth
//   din     : write data
//   rdata   : registered read data, updates only when en is high
module input_pre_sram_bank
  import input_pre_sram_pkg::*;
#(
  parameter int DW = PRE_SRAM_DW,
  parameter int DP = PRE_SRAM_DP,
  parameter int NB = pre_sram_mask_w(DW),
  parameter int IW = (DP > 1) ? $clog2(DP) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [NB-1:0] lane_we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_lane [DP];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (en) begin
          if (lane_we[gi]) begin
            mem_lane[addr] <= din[gi*8 +: 8];
          end
`ifdef INPUT_PRE_SRAM_WRITE_THROUGH_EN
          // Lanes being written forward the new byte; others return stored data.
          rd_q <= lane_we[gi] ? din[gi*8 +: 8] : mem_lane[addr];
`else
          // Non-blocking read sees the pre-write contents: read-first.
          rd_q <= mem_lane[addr];
`endif
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/input_pre_sram_mem.sv
// input_pre_sram_mem
// Single-port synchronous SRAM holding one ping-pong half of the input
// pre-processing buffer. One-cycle registered read, byte write mask, chip select.
// Optional feature macro: INPUT_PRE_SRAM_WRITE_THROUGH_EN (write-through read
// data on write cycles; default is read-first).
// Ports:
//   clk     : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears dout only (not contents)
//   din     : write data
//   addr    : word address; addresses >= DP are out of range
//   cs      : chip select, cycle ignored when low
//   we      : 1 = write, 0 = read
//   wem     : byte write mask, 1 = lane written
//   dout    : read data, 1-cycle latency, holds between enabled accesses
module input_pre_sram_mem
  import input_pre_sram_pkg::*;
#(
  parameter int DW = PRE_SRAM_DW,
  parameter int AW = PRE_SRAM_AW,
  parameter int DP = PRE_SRAM_DP
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic [DW-1:0]                  din,
  input  logic [AW-1:0]                  addr,
  input  logic                           cs,
  input  logic                           we,
  input  logic [pre_sram_mask_w(DW)-1:0] wem,
  output logic [DW-1:0]                  dout
);

  localparam int NB = pre_sram_mask_w(DW);
  localparam int IW = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

  logic          in_range;
  logic          access;
  logic          wr_cycle;
  logic [NB-1:0] lane_we;
  logic [DW-1:0] bank_rdata;
  logic          zero_d;
  logic          zero_q;

  // Out-of-range addresses never reach the bank, so nothing aliases or wraps.
  assign in_range = (addr <= LAST_ADDR);
  // Reset wins over any access in the same cycle.
  assign access   = i_rst_n & cs & in_range;
  assign wr_cycle = access & we;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_mask
      assign lane_we[gi] = wr_cycle & wem[gi];
    end
  endgenerate

  input_pre_sram_bank #(
    .DW (DW),
    .DP (DP),
    .NB (NB),
    .IW (IW)
  ) u_bank (
    .clk     (clk),
    .en      (access),
    .lane_we (lane_we),
    .addr    (addr[IW-1:0]),
    .din     (din),
    .rdata   (bank_rdata)
  );

  // zero_q forces dout to 0 after reset or an out-of-range access. The bank's
  // read register only moves on in-range accesses, so together they form the
  // output register: dout changes only on enabled edges or reset.
  always_comb begin
    zero_d = zero_q;
    if (cs) begin
      zero_d = ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign dout = zero_q ? '0 : bank_rdata;

endmodule

// File: tb/tb_input_pre_sram_mem.sv
module tb_input_pre_sram_mem;

  localparam int TB_DW = 8;
  localparam int TB_AW = 10;
  localparam int TB_DP = 768;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [TB_DW-1:0] din;
  logic [TB_AW-1:0] addr;
  logic             cs;
  logic             we;
  logic [0:0]       wem;
  logic [TB_DW-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain array of words plus the last value on dout.
  logic [7:0] ref_mem [1024];
  logic [7:0] ref_dout;

  input_pre_sram_mem #(
    .DW (TB_DW),
    .AW (TB_AW),
    .DP (TB_DP)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .din     (din),
    .addr    (addr),
    .cs      (cs),
    .we      (we),
    .wem     (wem),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // Monitor: dout is sampled on the falling edge after each issued cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (dout !== e.exp) begin
        n_fail++;
        $display("FAIL %s: dout=%02h expected=%02h", e.name, dout, e.exp);
      end else begin
        $display("ok   %s: dout=%02h", e.name, dout);
      end
    end
  end

  // Drive one cycle, predict dout after the coming edge, push the prediction.
  task automatic cyc(input string name, input logic rst_n, input logic c,
                     input logic w, input logic m, input int a, input logic [7:0] d);
    exp_t e;
    logic [7:0] nw;
    i_rst_n = rst_n; cs = c; we = w; wem = m; addr = TB_AW'(a); din = d;
    if (!rst_n) begin
      ref_dout = 8'h00;
    end else if (c) begin
      if (a >= TB_DP) begin
        ref_dout = 8'h00;
      end else if (w) begin
        nw = m ? d : ref_mem[a];
`ifdef INPUT_PRE_SRAM_WRITE_THROUGH_EN
        ref_dout = nw;
`else
        ref_dout = ref_mem[a];
`endif
        ref_mem[a] = nw;
      end else begin
        ref_dout = ref_mem[a];
      end
    end
    e.name = name;
    e.exp  = ref_dout;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string n, input int a, input logic [7:0] d);
    cyc(n, 1'b1, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input string n, input int a);
    cyc(n, 1'b1, 1'b1, 1'b0, 1'b0, a, 8'h00);
  endtask

  initial begin
    i_rst_n = 1'b0; cs = 1'b0; we = 1'b0; wem = 1'b0; addr = '0; din = '0;
    ref_dout = 8'h00;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // Power-up reset: dout must be 0.
    cyc("reset_init", 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    cyc("reset_init2", 1'b0, 1'b1, 1'b1, 1'b1, 3, 8'hEE);

    // Full sweep: write every address, then read back sequentially.
    for (int a = 0; a < 1024; a++) wr("sweep_wr", a, 8'(a) ^ 8'h5A);
    for (int a = 0; a < 1024; a++) rd("sweep_rd", a);
    rd("sweep_wrap_rd0", 0);

    // Reset after a read of 0xA5.
    wr("pre_a5_wr", 1, 8'hA5);
    rd("pre_a5_rd", 1);
    cyc("reset_1", 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    cyc("reset_2", 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h77);
    cyc("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h00);
    rd("post_reset_rd", 1);

    // Write then read, neighbour untouched.
    wr("wr5", 5, 8'h3C);
    rd("rd5", 5);
    rd("rd6_unaffected", 6);

    // Masked write and chip-select-low write.
    wr("prewr7", 7, 8'h11);
    cyc("wr7_mask0", 1'b1, 1'b1, 1'b1, 1'b0, 7, 8'hFF);
    rd("rd7_masked", 7);
    cyc("wr7_cs0", 1'b1, 1'b0, 1'b1, 1'b1, 7, 8'hFF);
    cyc("idle_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'h00);
    rd("rd7_cs0", 7);

    // Read-during-write.
    wr("prewr9", 9, 8'h10);
    wr("rdw9", 9, 8'h20);
    rd("rd9", 9);

    // Range limit at DP-1 / DP.
    wr("wr767", 767, 8'h55);
    wr("wr768_oor", 768, 8'h55);
    rd("rd767", 767);
    rd("rd768_oor", 768);
    rd("rd0_unchanged", 0);
    rd("rd1023_oor", 1023);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 1023)), 8'($urandom));
    end

    // Let the monitor consume the last prediction.
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
